// File: rtl/gnrl_pipe_skid_if.sv
// Valid/ready handshake bundle for the 2-entry pipeline slice.
// slave is the slice side; master is the upstream/downstream driver side.
interface gnrl_pipe_skid_if #(
  parameter int DW = 32
);
  logic          flush;
  logic          i_valid;
  logic          i_ready;
  logic [DW-1:0] i_data;
  logic          o_valid;
  logic          o_ready;
  logic [DW-1:0] o_data;
  logic [1:0]    o_cnt;

  modport slave (
    input  flush, i_valid, i_data, o_ready,
    output i_ready, o_valid, o_data, o_cnt
  );

  modport master (
    output flush, i_valid, i_data, o_ready,
    input  i_ready, o_valid, o_data, o_cnt
  );
endinterface

// File: rtl/gnrl_pipe_skid.sv
// 2-entry valid/ready slice with registered outputs and a skid entry; 1-cycle latency.
// Backpressure: i_ready depends only on the skid valid and flush, never on o_ready.
module gnrl_pipe_skid #(
  parameter int DW = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  gnrl_pipe_skid_if.slave        p
);

  // State encoding is {skid_v, main_v}; 2'b10 cannot be reached.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] main_dat_q, main_dat_d;
  logic [DW-1:0] skid_dat_q, skid_dat_d;

  logic main_v;
  logic skid_v;
  logic acc;
  logic pop;

  assign main_v = state_q[0];
  assign skid_v = state_q[1];

  assign p.i_ready = ~skid_v & ~p.flush;
  assign p.o_valid = main_v;
  assign p.o_data  = main_dat_q;
  assign p.o_cnt   = {1'b0, main_v} + {1'b0, skid_v};

  assign acc = p.i_valid & p.i_ready;
  assign pop = main_v & p.o_ready;

  always_comb begin
    state_d    = state_q;
    main_dat_d = main_dat_q;
    skid_dat_d = skid_dat_q;
    case (state_q)
      EMPTY: begin
        if (acc) begin
          main_dat_d = p.i_data;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (acc && pop) begin
          main_dat_d = p.i_data;
        end else if (acc) begin
          skid_dat_d = p.i_data;
          state_d    = FULL;
        end else if (pop) begin
          state_d    = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          main_dat_d = skid_dat_q;
          state_d    = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush only clears the valids; data registers may keep stale contents.
    if (p.flush) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      main_dat_q <= '0;
      skid_dat_q <= '0;
    end else begin
      state_q    <= state_d;
      main_dat_q <= main_dat_d;
      skid_dat_q <= skid_dat_d;
    end
  end

endmodule

// File: tb/tb_gnrl_pipe_skid.sv
// Directed bench for gnrl_pipe_skid: driver pushes accepted beats into a scoreboard,
// an independent monitor pops and compares every beat leaving the slice.
module tb_gnrl_pipe_skid;

  localparam int DW = 32;

  logic clk;
  logic rst;

  gnrl_pipe_skid_if #(.DW(DW)) ifc ();

  gnrl_pipe_skid #(.DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .p   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [DW-1:0] sb_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: a beat leaves on the edge after a negedge that sees o_valid & o_ready.
  always @(negedge clk) begin
    if (!rst && ifc.o_valid && ifc.o_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_beat", ifc.o_data, 32'hxxxxxxxx);
      end else begin
        chk("beat_data", ifc.o_data, sb_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send(input logic [DW-1:0] d);
    bit ok;
    ok = 1'b0;
    ifc.i_valid = 1'b1;
    ifc.i_data  = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ifc.i_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) sb_q.push_back(d);
    else chk("send_timeout", 32'd0, 32'd1);
    step();
    ifc.i_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    ifc.o_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!ifc.o_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("drain_timeout", 32'd0, 32'd1);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. Reset with a beat offered
    rst         = 1'b1;
    ifc.flush   = 1'b0;
    ifc.i_valid = 1'b1;
    ifc.i_data  = 32'hDEADBEEF;
    ifc.o_ready = 1'b0;
    @(negedge clk);
    chk("rst_o_valid", {31'd0, ifc.o_valid}, 32'd0);
    chk("rst_o_data",  ifc.o_data, 32'd0);
    chk("rst_o_cnt",   {30'd0, ifc.o_cnt}, 32'd0);
    chk("rst_i_ready", {31'd0, ifc.i_ready}, 32'd1);
    step();
    rst = 1'b0;
    send(32'hDEADBEEF);
    @(negedge clk);
    chk("t1_o_valid", {31'd0, ifc.o_valid}, 32'd1);
    chk("t1_o_data",  ifc.o_data, 32'hDEADBEEF);
    step();
    drain();

    // 2. Streaming at full throughput
    ifc.o_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      ifc.i_valid = 1'b1;
      ifc.i_data  = DW'(i);
      @(negedge clk);
      chk("t2_i_ready", {31'd0, ifc.i_ready}, 32'd1);
      if (i > 1) begin
        chk("t2_o_cnt",  {30'd0, ifc.o_cnt}, 32'd1);
        chk("t2_o_data", ifc.o_data, 32'(i - 1));
      end
      sb_q.push_back(DW'(i));
      step();
    end
    ifc.i_valid = 1'b0;
    @(negedge clk);
    chk("t2_last_cnt", {30'd0, ifc.o_cnt}, 32'd1);
    step();
    drain();

    // 3. Backpressure fills the skid entry
    ifc.o_ready = 1'b0;
    send(32'hA);
    send(32'hB);
    ifc.i_valid = 1'b1;
    ifc.i_data  = 32'hC;
    @(negedge clk);
    chk("t3_o_cnt",   {30'd0, ifc.o_cnt}, 32'd2);
    chk("t3_i_ready", {31'd0, ifc.i_ready}, 32'd0);
    chk("t3_o_data",  ifc.o_data, 32'hA);
    step();
    ifc.o_ready = 1'b1;
    send(32'hC);
    drain();

    // 4. Flush while FULL with a beat offered
    ifc.o_ready = 1'b0;
    send(32'h10);
    send(32'h20);
    ifc.flush   = 1'b1;
    ifc.i_valid = 1'b1;
    ifc.i_data  = 32'h30;
    @(negedge clk);
    chk("t4_i_ready", {31'd0, ifc.i_ready}, 32'd0);
    step();
    ifc.flush   = 1'b0;
    ifc.i_valid = 1'b0;
    sb_q.delete();
    @(negedge clk);
    chk("t4_o_valid", {31'd0, ifc.o_valid}, 32'd0);
    chk("t4_o_cnt",   {30'd0, ifc.o_cnt}, 32'd0);
    step();

    // 4b. Flush coinciding with a pop: the popped beat still completes
    send(32'h40);
    ifc.o_ready = 1'b1;
    ifc.flush   = 1'b1;
    @(negedge clk);
    step();
    ifc.flush   = 1'b0;
    ifc.o_ready = 1'b0;
    chk("t4b_sb_empty", sb_q.size(), 32'd0);
    @(negedge clk);
    chk("t4b_o_valid", {31'd0, ifc.o_valid}, 32'd0);
    step();

    // 5. Output stability under stall with random upstream traffic
    send(32'h55);
    for (int i = 0; i < 5; i++) begin
      ifc.i_valid = 1'b1;
      ifc.i_data  = $urandom;
      @(negedge clk);
      if (ifc.i_ready) sb_q.push_back(ifc.i_data);
      chk("t5_o_data", ifc.o_data, 32'h55);
      chk("t5_cnt_le2", {31'd0, (ifc.o_cnt <= 2'd2)}, 32'd1);
      step();
    end
    ifc.i_valid = 1'b0;
    chk("t5_accepted", sb_q.size(), 32'd2);
    drain();

    // 6. Asynchronous reset between edges while FULL
    ifc.o_ready = 1'b0;
    send(32'h7);
    send(32'h8);
    @(negedge clk);
    chk("t6_full", {30'd0, ifc.o_cnt}, 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_o_valid", {31'd0, ifc.o_valid}, 32'd0);
    chk("t6_o_cnt",   {30'd0, ifc.o_cnt}, 32'd0);
    sb_q.delete();
    step();
    rst = 1'b0;
    step();

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
